// File: rtl/neuron_activation_packer_pkg.sv
// Shared types and width helpers for the activation packer and its requantizer.
package neuron_activation_packer_pkg;

    typedef enum logic {
        StCollect = 1'b0,
        StFull    = 1'b1
    } pack_state_e;

    // Width of a raw accumulated dot product for WIDTH-bit operands.
    function automatic int unsigned res_w(input int unsigned width);
        return 2 * width + 1;
    endfunction

endpackage

// File: rtl/neuron_activation_packer_requant_sat.sv
// Combinational bias-add, optional ReLU, arithmetic right shift and saturation to WIDTH bits.
module requant_sat
    import neuron_activation_packer_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned SHIFT = 4,
    parameter bit          RELU  = 1'b1
) (
    input  logic signed [res_w(WIDTH)-1:0] result_i,
    input  logic signed [res_w(WIDTH)-1:0] bias_i,
    output logic        [WIDTH-1:0]        element_o,
    output logic                           sat_o
);

    localparam int unsigned ResW = res_w(WIDTH);
    // One guard bit above the operands so the bias add cannot overflow.
    localparam int unsigned SumW = ResW + 1;

    localparam logic signed [SumW-1:0] MaxVal = {{(SumW - WIDTH + 1){1'b0}}, {(WIDTH - 1){1'b1}}};
    localparam logic signed [SumW-1:0] MinVal = {{(SumW - WIDTH + 1){1'b1}}, {(WIDTH - 1){1'b0}}};

    logic signed [SumW-1:0] sum;
    logic signed [SumW-1:0] relu_sum;
    logic signed [SumW-1:0] shifted;

    always_comb begin
        sum      = {result_i[ResW-1], result_i} + {bias_i[ResW-1], bias_i};
        relu_sum = (RELU && sum[SumW-1]) ? '0 : sum;
        shifted  = relu_sum >>> SHIFT;

        if (shifted > MaxVal) begin
            element_o = MaxVal[WIDTH-1:0];
            sat_o     = 1'b1;
        end else if (shifted < MinVal) begin
            element_o = MinVal[WIDTH-1:0];
            sat_o     = 1'b1;
        end else begin
            element_o = shifted[WIDTH-1:0];
            sat_o     = 1'b0;
        end
    end

endmodule

// File: rtl/neuron_activation_packer.sv
// Collects NUM_NEURONS requantized neuron results into one packed vector on a valid/ready output.
module neuron_activation_packer
    import neuron_activation_packer_pkg::*;
#(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned NUM_NEURONS = 4,
    parameter int unsigned SHIFT       = 4,
    parameter bit          RELU        = 1'b1,
    parameter bit          EDGE_IN     = 1'b1
) (
    input  logic                                   clk,
    input  logic                                   reset_n,
    input  logic                                   clear,
    input  logic                                   in_valid,
    output logic                                   in_ready,
    input  logic signed [res_w(WIDTH)-1:0]         in_result,
    input  logic [res_w(WIDTH)*NUM_NEURONS-1:0]    biases,
    output logic                                   out_valid,
    input  logic                                   out_ready,
    output logic [WIDTH*NUM_NEURONS-1:0]           out_data,
    output logic                                   out_saturated
);

    localparam int unsigned ResW    = res_w(WIDTH);
    localparam int unsigned IdxW    = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(NUM_NEURONS - 1);

    pack_state_e                    state_q, state_d;
    logic [IdxW-1:0]                idx_q, idx_d;
    logic                           in_valid_q;
    logic [WIDTH*NUM_NEURONS-1:0]   data_q, data_d;
    logic                           sat_q, sat_d;

    logic                           accept;
    logic signed [ResW-1:0]         bias_sel;
    logic [WIDTH-1:0]               elem;
    logic                           elem_sat;

    assign in_ready      = (state_q == StCollect);
    assign out_valid     = (state_q == StFull);
    assign out_data      = data_q;
    assign out_saturated = sat_q;

    // Edge mode only counts a low-to-high transition of the upstream done flag.
    assign accept = in_valid & in_ready & (EDGE_IN ? ~in_valid_q : 1'b1);

    always_comb begin
        bias_sel = '0;
        for (int i = 0; i < NUM_NEURONS; i++) begin
            if (idx_q == IdxW'(i)) begin
                bias_sel = biases[ResW*i +: ResW];
            end
        end
    end

    requant_sat #(
        .WIDTH (WIDTH),
        .SHIFT (SHIFT),
        .RELU  (RELU)
    ) u_requant (
        .result_i  (in_result),
        .bias_i    (bias_sel),
        .element_o (elem),
        .sat_o     (elem_sat)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        data_d  = data_q;
        sat_d   = sat_q;

        if (clear) begin
            state_d = StCollect;
            idx_d   = '0;
            sat_d   = 1'b0;
        end else begin
            unique case (state_q)
                StCollect: begin
                    if (accept) begin
                        for (int i = 0; i < NUM_NEURONS; i++) begin
                            if (idx_q == IdxW'(i)) begin
                                data_d[WIDTH*i +: WIDTH] = elem;
                            end
                        end
                        sat_d = (idx_q == '0) ? elem_sat : (sat_q | elem_sat);
                        if (idx_q == LastIdx) begin
                            idx_d   = '0;
                            state_d = StFull;
                        end else begin
                            idx_d = idx_q + 1'b1;
                        end
                    end
                end
                StFull: begin
                    if (out_ready) begin
                        state_d = StCollect;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= StCollect;
            idx_q      <= '0;
            in_valid_q <= 1'b0;
            data_q     <= '0;
            sat_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            in_valid_q <= in_valid;
            data_q     <= data_d;
            sat_q      <= sat_d;
        end
    end

endmodule
